// File: rtl/vx_tcu_fp32_pack_if.sv
// vx_tcu_fp32_pack_if: FP32 element stream in,
// packed 2x16-bit word stream out.
interface vx_tcu_fp32_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_fmt;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_fflags;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_fmt, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_fflags, out_last
  );

  modport slave (
    input  in_valid, in_data, in_fmt, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_fflags, out_last
  );
endinterface

// File: rtl/vx_tcu_fp32_pack.sv
// vx_tcu_fp32_pack: rounds FP32 to FP16/BF16 (RNE)
// and packs element pairs into 32-bit words.
module vx_tcu_fp32_pack #(
  parameter string INSTANCE_ID = ""
) (
  input logic               clk,
  input logic               reset,
  vx_tcu_fp32_pack_if.slave bus
);
  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;

  localparam logic [4:0] F_NV = 5'h10;
  localparam logic [4:0] F_OF = 5'h04;
  localparam logic [4:0] F_UF = 5'h02;
  localparam logic [4:0] F_NX = 5'h01;

  logic unused_id;
  assign unused_id = (INSTANCE_ID != "");

  logic        c_sign;
  logic [7:0]  c_exp;
  logic [22:0] c_man;
  logic        is_fp16;
  logic        is_bf16;

  assign c_sign  = bus.in_data[31];
  assign c_exp   = bus.in_data[30:23];
  assign c_man   = bus.in_data[22:0];
  assign is_fp16 = (bus.in_fmt == TCU_FP16_ID);
  assign is_bf16 = (bus.in_fmt == TCU_BF16_ID);

  logic [15:0] c_res;
  logic [4:0]  c_flg;
  logic [14:0] nrm_sum;
  logic [4:0]  sub_sh;
  logic [34:0] sub_ext;
  logic [10:0] sub_sum;
  logic [15:0] bf_sum;
  logic        g;
  logic        st;
  logic        rup;

  // Convert: round the incoming FP32 element.
  always_comb begin
    c_res   = '0;
    c_flg   = '0;
    nrm_sum = '0;
    sub_sh  = '0;
    sub_ext = '0;
    sub_sum = '0;
    bf_sum  = '0;
    g       = 1'b0;
    st      = 1'b0;
    rup     = 1'b0;
    unique case (1'b1)
      is_fp16: begin
        if (c_exp == 8'hFF) begin
          if (c_man == '0) begin
            c_res = {c_sign, 15'h7C00};
          end else begin
            c_res    = 16'h7E00;
            c_flg[4] = ~c_man[22];
          end
        end else if (c_exp == 8'h00) begin
          c_res = {c_sign, 15'h0000};
          if (c_man != '0) c_flg = F_UF | F_NX;
        end else if (c_exp > 8'd142) begin
          c_res = {c_sign, 15'h7C00};
          c_flg = F_OF | F_NX;
        end else if (c_exp >= 8'd113) begin
          g   = c_man[12];
          st  = |c_man[11:0];
          rup = g & (st | c_man[13]);
          nrm_sum = {5'(c_exp - 8'd112), c_man[22:13]}
                  + 15'(rup);
          if (nrm_sum[14:10] == 5'h1F) begin
            c_res = {c_sign, 15'h7C00};
            c_flg = F_OF | F_NX;
          end else begin
            c_res    = {c_sign, nrm_sum};
            c_flg[0] = g | st;
          end
        end else if (c_exp >= 8'd102) begin
          sub_sh  = 5'(8'd126 - c_exp);
          sub_ext = 35'({1'b1, c_man, 24'h0} >> sub_sh);
          g   = sub_ext[23];
          st  = |sub_ext[22:0];
          rup = g & (st | sub_ext[24]);
          sub_sum = sub_ext[34:24] + 11'(rup);
          c_res   = {c_sign, 4'h0, sub_sum};
          if (g | st) c_flg = F_UF | F_NX;
        end else begin
          c_res = {c_sign, 15'h0000};
          c_flg = F_UF | F_NX;
        end
      end
      is_bf16: begin
        if (c_exp == 8'hFF) begin
          if (c_man == '0) begin
            c_res = {c_sign, 15'h7F80};
          end else begin
            c_res    = 16'h7FC0;
            c_flg[4] = ~c_man[22];
          end
        end else if (c_exp == 8'h00) begin
          c_res = {c_sign, 15'h0000};
          if (c_man != '0) c_flg = F_UF | F_NX;
        end else begin
          g   = bus.in_data[15];
          st  = |bus.in_data[14:0];
          rup = g & (st | bus.in_data[16]);
          bf_sum = bus.in_data[31:16] + 16'(rup);
          c_res  = bf_sum;
          if (bf_sum[14:7] == 8'hFF) begin
            c_flg = F_OF | F_NX;
          end else begin
            c_flg[0] = g | st;
          end
        end
      end
      default: begin
        c_res = '0;
        c_flg = F_NV;
      end
    endcase
  end

  logic        s1_valid;
  logic [15:0] s1_data;
  logic [4:0]  s1_flags;
  logic        s1_last;
  logic        lo_valid;
  logic [15:0] lo_data;
  logic [4:0]  lo_flags;
  logic        o_valid;
  logic [31:0] o_data;
  logic [4:0]  o_flags;
  logic        o_last;

  logic out_free;
  logic s1_needs_out;
  logic s1_advance;
  logic word_wr;
  logic in_fire;

  assign out_free     = !o_valid || bus.out_ready;
  assign s1_needs_out = lo_valid || s1_last;
  assign s1_advance   = s1_valid
                     && (!s1_needs_out || out_free);
  assign word_wr      = s1_valid && s1_needs_out
                     && out_free;
  assign in_fire      = bus.in_valid && bus.in_ready;

  assign bus.in_ready   = !s1_valid || s1_advance;
  assign bus.out_valid  = o_valid;
  assign bus.out_data   = o_data;
  assign bus.out_fflags = o_flags;
  assign bus.out_last   = o_last;

  // S1: hold one converted element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_flags <= '0;
      s1_last  <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= c_res;
      s1_flags <= c_flg;
      s1_last  <= bus.in_last;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Lo slot: park the first half of a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_valid <= 1'b0;
      lo_data  <= '0;
      lo_flags <= '0;
    end else if (s1_advance) begin
      if (lo_valid) begin
        lo_valid <= 1'b0;
      end else if (!s1_last) begin
        lo_valid <= 1'b1;
        lo_data  <= s1_data;
        lo_flags <= s1_flags;
      end
    end
  end

  // Output register: load a word or drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_flags <= '0;
      o_last  <= 1'b0;
    end else if (word_wr) begin
      o_valid <= 1'b1;
      o_last  <= s1_last;
      if (lo_valid) begin
        o_data  <= {s1_data, lo_data};
        o_flags <= s1_flags | lo_flags;
      end else begin
        o_data  <= {16'h0000, s1_data};
        o_flags <= s1_flags;
      end
    end else if (bus.out_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vx_tcu_fp32_pack.sv
// tb_vx_tcu_fp32_pack: directed vectors for the
// FP32 -> FP16/BF16 pack stage.
module tb_vx_tcu_fp32_pack;
  localparam logic [3:0] H = 4'd1;
  localparam logic [3:0] B = 4'd2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  vx_tcu_fp32_pack_if bus ();

  vx_tcu_fp32_pack #(.INSTANCE_ID("tb")) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [37:0] mon_q[$];

  always @(posedge clk) begin
    if (reset && bus.out_valid && bus.out_ready)
      mon_q.push_back({bus.out_last, bus.out_fflags,
                       bus.out_data});
  end

  typedef struct {
    logic [31:0] a;
    logic [3:0]  fa;
    logic [31:0] b;
    logic [3:0]  fb;
    logic        lb;
    logic [31:0] w;
    logic [4:0]  fl;
  } vec_t;

  vec_t tv[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d,
                      input logic [3:0] f,
                      input logic l);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_fmt   = f;
    bus.in_last  = l;
    do begin
      @(posedge clk);
      acc = bus.in_ready;
      n++;
    end while (!acc && n < 30);
    #1;
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=%h expected=accept", d);
    end
  endtask

  task automatic expect_word(input string name,
                             input logic [31:0] w,
                             input logic [4:0] fl,
                             input logic lst);
    int          n;
    logic [37:0] e;
    n = 0;
    while (mon_q.size() == 0 && n < 20) begin
      step();
      n++;
    end
    if (mon_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=none expected=%h",
               name, w);
    end else begin
      e = mon_q.pop_front();
      chk({name, "_data"}, e[31:0], w);
      chk({name, "_flags"}, 32'(e[36:32]), 32'(fl));
      chk({name, "_last"}, 32'(e[37]), 32'(lst));
    end
  endtask

  logic [31:0] bp_in[8];
  logic [31:0] bp_w[4];
  logic [37:0] held;
  int          unstable;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;

    tv[0]  = '{32'h3F800000, H, 32'h40000000, H, 1'b1,
               32'h40003C00, 5'h00};
    tv[1]  = '{32'h3F808000, B, 32'h3F818000, B, 1'b0,
               32'h3F823F80, 5'h01};
    tv[2]  = '{32'h47800000, H, 32'h33000000, H, 1'b0,
               32'h00007C00, 5'h07};
    tv[3]  = '{32'h7F800001, H, 32'hFF800000, H, 1'b1,
               32'hFC007E00, 5'h10};
    tv[4]  = '{32'h3F800000, B, 32'h3F800000, H, 1'b0,
               32'h3C003F80, 5'h00};
    tv[5]  = '{32'h3F800000, 4'd7, 32'h7FC00000, H, 1'b0,
               32'h7E000000, 5'h10};
    tv[6]  = '{32'h3F801000, H, 32'h3F803000, H, 1'b0,
               32'h3C023C00, 5'h01};
    tv[7]  = '{32'h33800000, H, 32'h38000000, H, 1'b0,
               32'h02000001, 5'h00};
    tv[8]  = '{32'h477FE000, H, 32'h477FF000, H, 1'b0,
               32'h7C007BFF, 5'h05};
    tv[9]  = '{32'h33000001, H, 32'h80000000, H, 1'b0,
               32'h80000001, 5'h03};
    tv[10] = '{32'h7F7FFFFF, B, 32'hFF800001, B, 1'b1,
               32'h7FC07F80, 5'h15};

    bp_in = '{32'h3F800000, 32'h40000000, 32'h40400000,
              32'h40800000, 32'h40A00000, 32'h40C00000,
              32'h40E00000, 32'h41000000};
    bp_w  = '{32'h40003C00, 32'h44004200,
              32'h46004500, 32'h48004700};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_fmt    = H;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_fflags", 32'(bus.out_fflags), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    reset = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      push(tv[i].a, tv[i].fa, 1'b0);
      push(tv[i].b, tv[i].fb, tv[i].lb);
      expect_word($sformatf("vec%0d", i),
                  tv[i].w, tv[i].fl, tv[i].lb);
    end

    // lone last element: latency and zero-filled hi half
    push(32'h3F800000, H, 1'b1);
    chk("lat_early", 32'(bus.out_valid), 32'd0);
    step();
    chk("lat_rise", 32'(bus.out_valid), 32'd1);
    expect_word("lone", 32'h00003C00, 5'h00, 1'b1);

    // odd group at full rate
    begin
      int t0;
      t0 = cyc;
      push(32'h3F800000, H, 1'b0);
      push(32'h40000000, H, 1'b0);
      push(32'h40400000, H, 1'b1);
      chk("odd_rate", 32'(cyc - t0), 32'd3);
    end
    expect_word("odd0", 32'h40003C00, 5'h00, 1'b0);
    expect_word("odd1", 32'h00004200, 5'h00, 1'b1);

    // backpressure with 8 elements
    bus.out_ready = 1'b0;
    unstable = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          push(bp_in[i], H, (i == 7));
      end
      begin
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
          step();
          n++;
        end
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        held = {bus.out_last, bus.out_fflags,
                bus.out_data};
        repeat (5) begin
          step();
          if ({bus.out_last, bus.out_fflags,
               bus.out_data} !== held)
            unstable++;
        end
        chk("bp_hold", 32'(unstable), 32'd0);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 4; i++)
      expect_word($sformatf("bp%0d", i), bp_w[i], 5'h00,
                  (i == 3));
    repeat (6) step();
    chk("bp_no_dup", 32'(mon_q.size()), 32'd0);

    // reset with a lo half pending
    push(32'h3F800000, H, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", bus.out_data, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    reset = 1'b1;
    repeat (4) step();
    chk("mid_rst_stray", 32'(mon_q.size()), 32'd0);
    push(32'h40000000, H, 1'b1);
    expect_word("post_rst", 32'h00004000, 5'h00, 1'b1);
    repeat (4) step();
    chk("post_rst_empty", 32'(mon_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_tcu_fp32_pack.md
# vx_tcu_fp32_pack

Narrowing/packing stage for the tensor-core result path. Accepts a stream of FP32 values, rounds each to FP16 or BF16 (round-to-nearest-even), and packs consecutive pairs into 32-bit words: first element in [15:0], second in [31:16]. This is the inverse of the operand unpack/widen performed at the FEDP input, so packed results can be written back as 16-bit operands. Valid/ready on both sides, full throughput.

## Interface
- INSTANCE_ID, "", debug identifier; unused in logic.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  input element accepted when in_valid && in_ready.
- in_data  in  32  FP32 value.
- in_fmt  in  4  target format per element: TCU_FP16_ID or TCU_BF16_ID (VX_tcu_pkg).
- in_last  in  1  final element of a group; forces emission of a partial word.
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.
- out_data  out  32  {hi16, lo16}.
- out_fflags  out  5  {NV, DZ, OF, UF, NX}, OR of the word's two elements' flags.
- out_last  out  1  word holds the group's last element.

## Operation
- S1 (convert): registers the rounded 16-bit result, flags, and last bit of an accepted element.
- FP16 rules: unbiased exp e = exp32-127. e > 15 after rounding -> 0x7C00|sign, OF|NX. -24 <= e < -14 -> subnormal, RNE on shifted-out bits (including hidden 1); nonzero inexact -> NX; tiny and inexact -> UF. Result rounding to 0x0400 is normal. e < -25 -> signed zero, UF|NX. e == -25 -> RNE decides zero or min subnormal (exact half ties to zero).
- FP32 subnormal inputs -> signed zero, UF|NX.
- BF16 rules: upper 16 bits, RNE with lsb = bit16, guard = bit15, sticky = |bits[14:0]; carry into exponent 0xFF -> infinity, OF|NX.
- Both: inf -> signed inf, no flags. qNaN -> canonical (FP16 0x7E00, BF16 0x7FC0), no flag; sNaN -> canonical, NV. Zero -> signed zero.
- Unsupported in_fmt -> 0x0000, NV set.
- DZ is always 0.
- S2 (pack): has a lo slot (16-bit + flags + valid bit) and an output register.
  - S1 element, lo slot empty, not last -> moves into lo slot; needs no output space.
  - S1 element, lo slot empty, last -> word {0x0000, elem}, out_last=1, flags from elem only.
  - S1 element, lo slot full -> word {elem, lo}, out_last = elem.last; lo slot cleared.
  - Moves that write a word require the output register free: !out_valid || out_ready.
- in_ready = !s1_valid || s1_advance (combinational); no in->out combinational path except via out_ready.
- Formats may differ between the two halves; no checking.

## Timing
- Reset values: out_valid=0, out_data=0, out_fflags=0, out_last=0, S1 empty, lo slot empty. in_ready=1 while in reset is deasserted and S1 is empty.
- Latency: word out_valid rises 2 cycles after acceptance of its completing element (hi or last) if the output register is free.
- Throughput: with out_ready held high, one element per cycle and one word per two elements.
- Backpressure: out_valid/out_data/out_fflags/out_last are held stable while out_valid && !out_ready. S1 stalls only when its move needs the output register and that register is busy. in_ready drops exactly when S1 is full and stalled.
- Simultaneous output handshake and new word: replacement occurs in the same cycle, with no bubble.
- Reset mid-operation: a pending lo half, S1, and the output register are discarded. No partial word is emitted after reset.

## Test plan
- FP16 pair: 0x3F800000 then 0x40000000 (fmt FP16) -> out_data 0x40003C00, fflags 0, out_last as given by the second element's in_last.
- BF16 ties: 0x3F808000 then 0x3F818000 -> 0x3F823F80, NX set.
- FP16 overflow/underflow: 0x47800000 then 0x33000000 -> lo 0x7C00 (OF|NX), hi 0x0000 (UF|NX); out_data 0x00007C00, fflags 0x07.
- NaN/inf: 0x7F800001 (sNaN) then 0xFF800000 with FP16 -> 0xFC007E00, NV only.
- Odd group: three elements 1.0, 2.0, 3.0 (FP16), last on the third -> words 0x40003C00 (last=0), then 0x00004200 (last=1).
- Backpressure/reset: stream 8 elements with out_ready low 5 cycles -> word held stable, in_ready drops after S1 fills, no loss or duplication. Reset asserted with a lo half pending -> outputs zero, no stray word after release.
